attrib07_serial_sub: RTL and testbench
======================================

// Module: attrib07_serial_sub
// PURPOSE
//   Digit-serial ripple-borrow subtractor: computes out = inp_a - inp_b, processing DIGIT bits
//   per cycle from the LSB upward. It is the subtract-side counterpart of the registered ripple
//   adder test block and exercises operator attributes under a multi-cycle FSM.
//   Sits between a valid/ready producer and consumer; operands are captured once per transaction.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; must be a multiple of DIGIT
//   DIGIT  2  bits processed per RUN cycle; 1 <= DIGIT <= WIDTH
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active-low (0 = reset)
//   in_valid   in   1      operand pair valid
//   in_ready   out  1      block can accept operands
//   inp_a      in   WIDTH  minuend
//   inp_b      in   WIDTH  subtrahend
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   out        out  WIDTH  difference (mod 2^WIDTH, or saturated, see CONFIGURATION)
//   borrow     out  1      1 when inp_a < inp_b (unsigned)
// BEHAVIOUR
//   - Reset (rst=0, async): state=IDLE, in_ready=0 during reset then 1, out_valid=0, out=0,
//     borrow=0, digit counter=0, captured operands=0.
//   - FSM: IDLE -> RUN on in_valid&&in_ready; RUN -> DONE after N=WIDTH/DIGIT RUN cycles;
//     DONE -> IDLE on out_valid&&out_ready.
//   - in_ready = (state==IDLE) && rst released; no overlap of transactions; operand changes while
//     busy are ignored.
//   - Capture edge E0 latches inp_a/inp_b, clears internal borrow and counter.
//   - RUN edge Ek (k=1..N): digit d=k-1: {bo, dd} = a[d] - b[d] - bi (DIGIT+1-bit unsigned
//     subtract, bi = borrow from previous digit, bo = new borrow); dd written to result
//     slice d; counter increments; counter wraps to 0 on entering DONE.
//   - The per-digit subtract operator carries (* ripple_adder *).
//   - out_valid rises after edge EN (latency N+1 edges from capture); out/borrow stable and
//     held while out_valid && !out_ready.
//   - out and borrow registered; updated only when entering DONE; otherwise hold last value.
//   - DIGIT==WIDTH: single RUN cycle, latency 2.
//   - Same-cycle out handshake and in_valid: in_ready is 0 in DONE, so new operand accepted
//     no earlier than the following cycle (back-to-back throughput: one result per N+2 cycles).
//   - Reset asserted mid-RUN or in DONE: transaction discarded, all outputs to reset values,
//     no partial result ever presented.
//   - Equal operands: out=0, borrow=0. inp_b=0: out=inp_a, borrow=0.
// CONFIGURATION
//   ATTRIB07_SUB_SAT_EN defined: on final borrow=1, out is forced to 0 (unsigned saturation);
//     borrow still reports 1.
//   Undefined: out is the WIDTH-bit wrap-around difference; borrow reports underflow.
// TESTING (WIDTH=8, DIGIT=2, N=4)
//   1. Reset mid-RUN: rst=0 during E2 -> out_valid=0, out=0, borrow=0 immediately (async);
//      after rst=1, in_ready=1.
//   2. a=8'h5A, b=8'h23 -> out=8'h37, borrow=0; out_valid exactly 5 edges after capture.
//   3. a=8'h10, b=8'h20 -> out=8'hF0, borrow=1 (SAT_EN: out=8'h00, borrow=1).
//   4. a=8'hFF, b=8'hFF -> out=8'h00, borrow=0; a=8'h00, b=8'h01 -> out=8'hFF, borrow=1
//      (full borrow ripple through all 4 digits).
//   5. Backpressure: out_ready=0 for 3 cycles after out_valid -> out/borrow/out_valid held,
//      in_ready=0, new inp_a/inp_b ignored; out_ready=1 -> IDLE next edge.
//   6. Back-to-back: in_valid held with 8'h09-8'h04, then 8'h04-8'h09 -> results 8'h05/0 then
//      8'hFB/1, captures 6 edges apart; repeat with DIGIT=8 -> latency 2.

Source files
------------

// File: rtl/attrib07_serial_sub_if.sv
// Operand/result handshake bundle for attrib07_serial_sub.
// The producer/consumer side uses the master modport; the subtractor uses the slave modport.
interface attrib07_serial_sub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] inp_a;
  logic [WIDTH-1:0] inp_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             borrow;

  modport master (
    output in_valid, inp_a, inp_b, out_ready,
    input  in_ready, out_valid, out, borrow
  );

  modport slave (
    input  in_valid, inp_a, inp_b, out_ready,
    output in_ready, out_valid, out, borrow
  );
endinterface

// File: rtl/attrib07_serial_sub.sv
// Digit-serial ripple-borrow subtractor: out = inp_a - inp_b, DIGIT bits per RUN cycle, LSB first.
// Optional ATTRIB07_SUB_SAT_EN: on final borrow the result saturates to 0 (borrow still reported).
module attrib07_serial_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  attrib07_serial_sub_if.slave  bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_last;
  logic             w_release;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_bi;
  logic [CW-1:0]    r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out;
  logic             r_borrow;

  logic [DIGIT:0]   w_diff;
  logic [WIDTH-1:0] w_dd_top;
  logic [WIDTH-1:0] w_res_nxt;
  logic [WIDTH-1:0] w_out_nxt;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and transition strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid && r_in_ready) begin
          w_state_nxt = ST_RUN;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_cnt == LAST_CNT) begin
          w_state_nxt = ST_DONE;
          w_last      = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        if (r_out_valid && bus.out_ready) begin
          w_state_nxt = ST_IDLE;
          w_release   = 1'b1;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // One digit of ripple-borrow subtract; the new digit enters at the top of a right-shifting result
  always_comb begin
    w_diff    = {1'b0, r_a[DIGIT-1:0]} - (* ripple_adder *) {1'b0, r_b[DIGIT-1:0]}
                - {{DIGIT{1'b0}}, r_bi};
    w_dd_top  = WIDTH'(w_diff[DIGIT-1:0]) << (WIDTH - DIGIT);
    w_res_nxt = (r_res >> DIGIT) | w_dd_top;
`ifdef ATTRIB07_SUB_SAT_EN
    if (w_diff[DIGIT]) begin
      w_out_nxt = {WIDTH{1'b0}};
    end else begin
      w_out_nxt = w_res_nxt;
    end
`else
    w_out_nxt = w_res_nxt;
`endif
  end

  // Operand capture, digit stepping and registered result/handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a         <= {WIDTH{1'b0}};
      r_b         <= {WIDTH{1'b0}};
      r_res       <= {WIDTH{1'b0}};
      r_bi        <= 1'b0;
      r_cnt       <= {CW{1'b0}};
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out       <= {WIDTH{1'b0}};
      r_borrow    <= 1'b0;
    end else begin
      r_in_ready <= (w_state_nxt == ST_IDLE);
      if (w_accept) begin
        r_a   <= bus.inp_a;
        r_b   <= bus.inp_b;
        r_bi  <= 1'b0;
        r_cnt <= {CW{1'b0}};
      end else if (r_state == ST_RUN) begin
        r_a   <= r_a >> DIGIT;
        r_b   <= r_b >> DIGIT;
        r_res <= w_res_nxt;
        r_bi  <= w_diff[DIGIT];
        r_cnt <= w_last ? {CW{1'b0}} : r_cnt + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        r_a   <= r_a;
        r_b   <= r_b;
        r_bi  <= r_bi;
        r_cnt <= r_cnt;
      end
      // Result is only published on entry to DONE, so a partial value is never visible
      if (w_last) begin
        r_out       <= w_out_nxt;
        r_borrow    <= w_diff[DIGIT];
        r_out_valid <= 1'b1;
      end else if (w_release) begin
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= r_out_valid;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out       = r_out;
  assign bus.borrow    = r_borrow;

endmodule

// File: tb/tb_attrib07_serial_sub.sv
// Self-checking bench for attrib07_serial_sub: directed cases plus random operands,
// run on a DIGIT=2 instance (N=4) and a DIGIT=8 instance (N=1).
module tb_attrib07_serial_sub;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   cyc;
  bit   sel;

  attrib07_serial_sub_if #(.WIDTH(8)) if0 ();
  attrib07_serial_sub_if #(.WIDTH(8)) if1 ();

  attrib07_serial_sub #(.WIDTH(8), .DIGIT(2)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  attrib07_serial_sub #(.WIDTH(8), .DIGIT(8)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  logic       m_in_ready;
  logic       m_out_valid;
  logic [7:0] m_out;
  logic       m_borrow;

  assign m_in_ready  = sel ? if1.in_ready  : if0.in_ready;
  assign m_out_valid = sel ? if1.out_valid : if0.out_valid;
  assign m_out       = sel ? if1.out       : if0.out;
  assign m_borrow    = sel ? if1.borrow    : if0.borrow;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction, reduced mod 256
  task automatic model(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] e_out, output logic e_borrow);
    int d;
    d        = int'(a) - int'(b);
    e_borrow = (d < 0);
    e_out    = 8'((d + 256) % 256);
`ifdef ATTRIB07_SUB_SAT_EN
    if (e_borrow) e_out = 8'h00;
`endif
  endtask

  task automatic set_in(input bit s, input logic v, input logic [7:0] a, input logic [7:0] b);
    if (s) begin
      if1.in_valid = v; if1.inp_a = a; if1.inp_b = b;
    end else begin
      if0.in_valid = v; if0.inp_a = a; if0.inp_b = b;
    end
  endtask

  task automatic set_ordy(input bit s, input logic r);
    if (s) if1.out_ready = r;
    else   if0.out_ready = r;
  endtask

  task automatic wait_in_ready(input string tag);
    int budget;
    budget = 0;
    while (!m_in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 50) check({tag, "_in_ready_timeout"}, 32'd0, 32'd1);
  endtask

  // One transaction: capture, count edges to out_valid, hold 'hold' cycles, then release
  task automatic txn(input bit s, input int n, input logic [7:0] a, input logic [7:0] b,
                     input int hold, input string tag);
    int         edges;
    logic [7:0] e_out;
    logic       e_b;
    sel = s;
    model(a, b, e_out, e_b);
    @(negedge clk);
    set_ordy(s, 1'b0);
    set_in(s, 1'b1, a, b);
    wait_in_ready(tag);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    set_in(s, 1'b0, 8'($urandom), 8'($urandom));
    while (!m_out_valid && edges < 50) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check({tag, "_latency"}, 32'(edges), 32'(n + 1));
    check({tag, "_out"}, 32'(m_out), 32'(e_out));
    check({tag, "_borrow"}, 32'(m_borrow), 32'(e_b));
    for (int i = 0; i < hold; i++) begin
      set_in(s, 1'b1, 8'($urandom), 8'($urandom));
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(m_out_valid), 32'd1);
      check({tag, "_hold_out"}, 32'(m_out), 32'(e_out));
      check({tag, "_hold_borrow"}, 32'(m_borrow), 32'(e_b));
      check({tag, "_hold_in_ready"}, 32'(m_in_ready), 32'd0);
    end
    set_in(s, 1'b0, 8'h00, 8'h00);
    set_ordy(s, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_ordy(s, 1'b0);
    check({tag, "_release_valid"}, 32'(m_out_valid), 32'd0);
    check({tag, "_release_in_ready"}, 32'(m_in_ready), 32'd1);
  endtask

  // Back-to-back: in_valid held high, out_ready held high; captures N+2 cycles apart
  task automatic b2b(input bit s, input int n, input string tag);
    int         t0;
    int         t1;
    int         budget;
    logic [7:0] e_out;
    logic       e_b;
    sel = s;
    @(negedge clk);
    set_ordy(s, 1'b1);
    set_in(s, 1'b1, 8'h09, 8'h04);
    wait_in_ready(tag);
    @(posedge clk);
    t0 = cyc;
    @(negedge clk);
    set_in(s, 1'b1, 8'h04, 8'h09);
    budget = 0;
    while (!m_out_valid && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check({tag, "_r1_out"}, 32'(m_out), 32'h05);
    check({tag, "_r1_borrow"}, 32'(m_borrow), 32'd0);
    @(negedge clk);
    check({tag, "_in_ready_after_release"}, 32'(m_in_ready), 32'd1);
    @(posedge clk);
    t1 = cyc;
    check({tag, "_capture_spacing"}, 32'(t1 - t0), 32'(n + 2));
    @(negedge clk);
    set_in(s, 1'b0, 8'h00, 8'h00);
    model(8'h04, 8'h09, e_out, e_b);
    budget = 0;
    while (!m_out_valid && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check({tag, "_r2_out"}, 32'(m_out), 32'(e_out));
    check({tag, "_r2_borrow"}, 32'(m_borrow), 32'(e_b));
    @(negedge clk);
    set_ordy(s, 1'b0);
    check({tag, "_r2_released"}, 32'(m_out_valid), 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    sel     = 1'b0;
    rst     = 1'b0;
    set_in(1'b0, 1'b0, 8'h00, 8'h00);
    set_in(1'b1, 1'b0, 8'h00, 8'h00);
    set_ordy(1'b0, 1'b0);
    set_ordy(1'b1, 1'b0);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_in_ready", 32'(m_in_ready), 32'd0);
    check("reset_out_valid", 32'(m_out_valid), 32'd0);
    check("reset_out", 32'(m_out), 32'h00);
    check("reset_borrow", 32'(m_borrow), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_reset_in_ready", 32'(m_in_ready), 32'd1);

    // Directed, DIGIT=2 (N=4); first one with 3 cycles of backpressure
    txn(1'b0, 4, 8'h5A, 8'h23, 3, "d2_5a_23_bp");
    txn(1'b0, 4, 8'h10, 8'h20, 0, "d2_10_20");
    txn(1'b0, 4, 8'hFF, 8'hFF, 0, "d2_ff_ff");
    txn(1'b0, 4, 8'h00, 8'h01, 1, "d2_00_01");
    txn(1'b0, 4, 8'hC3, 8'h00, 0, "d2_c3_00");

    // Reset asserted mid-RUN (shortly after the second RUN edge)
    @(negedge clk);
    set_in(1'b0, 1'b1, 8'h5A, 8'h23);
    wait_in_ready("mid_rst");
    @(posedge clk);
    @(negedge clk);
    set_in(1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(m_out_valid), 32'd0);
    check("mid_rst_out", 32'(m_out), 32'h00);
    check("mid_rst_borrow", 32'(m_borrow), 32'd0);
    check("mid_rst_in_ready", 32'(m_in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready_after", 32'(m_in_ready), 32'd1);
    repeat (6) @(negedge clk);
    check("mid_rst_no_partial", 32'(m_out_valid), 32'd0);

    // Back-to-back on both instances
    b2b(1'b0, 4, "b2b_d2");
    b2b(1'b1, 1, "b2b_d8");

    // Directed, DIGIT=8 (N=1)
    txn(1'b1, 1, 8'h5A, 8'h23, 2, "d8_5a_23_bp");
    txn(1'b1, 1, 8'h00, 8'h01, 0, "d8_00_01");

    // Random operands and backpressure on both instances
    for (int i = 0; i < 24; i++) begin
      txn(1'b0, 4, 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), "rnd_d2");
      txn(1'b1, 1, 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), "rnd_d8");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
